// File: rtl/shift_rows_if.sv
// Handshake bundle for shift_rows_pipe: upstream valid/ready with data and
// mode bit, downstream valid/ready with permuted data.
// slave  = the pipeline stage, master = the block driving it.
interface shift_rows_if #(
    parameter int LENGTH = 128
);
    logic              in_valid;
    logic              in_ready;
    logic              in_inv;
    logic [LENGTH-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [LENGTH-1:0] out_data;

    modport slave (
        input  in_valid, in_inv, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_inv, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: two-stage pipelined Rijndael ShiftRows / InvShiftRows for
// 4, 6 or 8 column states, direction chosen per block by in_inv.
// S1 registers the incoming block and mode bit, the byte permutation is pure
// wiring between S1 and S2, and S2 drives the output.
// Optional feature macro: SHIFT_ROWS_CNT_EN adds a 32-bit count of completed
// output transfers on blk_cnt; without it blk_cnt is constant zero.
module shift_rows_pipe #(
    parameter int BYTE = 8,
    parameter int NB   = 4
) (
    input  logic        clk,
    input  logic        rst,
    shift_rows_if.slave bus,
    output logic [31:0] blk_cnt
);
    // 32*NB for the Rijndael byte width of 8.
    localparam int LENGTH = 4 * BYTE * NB;

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    // Row shift amounts; the 256-bit state uses the wider offsets for rows 2/3.
    function automatic int row_shift(input int r);
        if (r == 0) return 0;
        if (NB == 8 && r == 2) return 3;
        if (NB == 8 && r == 3) return 4;
        return r;
    endfunction

    logic              s1_full_q, s1_full_d;
    logic              s1_inv_q,  s1_inv_d;
    logic [LENGTH-1:0] s1_data_q, s1_data_d;
    logic              s2_full_q, s2_full_d;
    logic [LENGTH-1:0] s2_data_q, s2_data_d;

    logic [LENGTH-1:0] fwd_perm;
    logic [LENGTH-1:0] inv_perm;
    logic              s2_unload;
    logic              s1_move;
    logic              in_fire;

    // Fixed byte routing: output byte (row, col) picks the source column
    // rotated by the row shift, one route per direction.
    for (genvar gi = 0; gi < 4 * NB; gi++) begin : g_byte
        localparam int ROW   = gi % 4;
        localparam int COL   = gi / 4;
        localparam int FWD_K = 4 * ((COL + row_shift(ROW)) % NB) + ROW;
        localparam int INV_K = 4 * ((COL - row_shift(ROW) + NB) % NB) + ROW;
        assign fwd_perm[LENGTH-1-BYTE*gi -: BYTE] = s1_data_q[LENGTH-1-BYTE*FWD_K -: BYTE];
        assign inv_perm[LENGTH-1-BYTE*gi -: BYTE] = s1_data_q[LENGTH-1-BYTE*INV_K -: BYTE];
    end

    // Handshake: S2 frees up when downstream takes it, S1 advances into a
    // free (or freeing) S2, and the input is accepted into a free (or freeing) S1.
    // in_ready is forced low while reset is held.
    assign s2_unload    = s2_full_q && bus.out_ready;
    assign s1_move      = s1_full_q && (!s2_full_q || s2_unload);
    assign bus.in_ready = !rst && (!s1_full_q || s1_move);
    assign in_fire      = bus.in_valid && bus.in_ready;

    // Next-state for both stages; a full stage that is not unloading holds.
    always_comb begin
        s1_full_d = s1_full_q;
        s1_inv_d  = s1_inv_q;
        s1_data_d = s1_data_q;
        s2_full_d = s2_full_q;
        s2_data_d = s2_data_q;
        if (in_fire) begin
            s1_full_d = 1'b1;
            s1_inv_d  = bus.in_inv;
            s1_data_d = bus.in_data;
        end else if (s1_move) begin
            s1_full_d = 1'b0;
        end
        if (s1_move) begin
            s2_full_d = 1'b1;
            s2_data_d = s1_inv_q ? inv_perm : fwd_perm;
        end else if (s2_unload) begin
            s2_full_d = 1'b0;
        end
    end

    // Pipeline registers; reset empties both stages and drops in-flight blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_full_q <= 1'b0;
            s1_inv_q  <= 1'b0;
            s1_data_q <= '0;
            s2_full_q <= 1'b0;
            s2_data_q <= '0;
        end else begin
            s1_full_q <= s1_full_d;
            s1_inv_q  <= s1_inv_d;
            s1_data_q <= s1_data_d;
            s2_full_q <= s2_full_d;
            s2_data_q <= s2_data_d;
        end
    end

    assign bus.out_valid = s2_full_q;
    assign bus.out_data  = s2_data_q;

`ifdef SHIFT_ROWS_CNT_EN
    logic [31:0] blk_cnt_q, blk_cnt_d;

    // Count completed output transfers; wraps naturally at 2^32.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (s2_unload) begin
            blk_cnt_d = blk_cnt_q + 32'd1;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q <= 32'd0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign blk_cnt = blk_cnt_q;
`else
    assign blk_cnt = 32'd0;
`endif

endmodule
